// File: rtl/rs_alu_pool.sv
// ALU reservation station: ENTRIES slots woken by CDB_N result buses, with up to
// ISSUE_N oldest-ready-first issues per cycle, a global freeze (rdy) and a flush.
module rs_alu_pool #(
    parameter int ENTRIES = 8,
    parameter int ISSUE_N = 2,
    parameter int CDB_N   = 3,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 6,
    parameter int ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OP_W-1:0]           in_op,
    input  logic [TAG_W-1:0]          in_tagx,
    input  logic [TAG_W-1:0]          in_tagy,
    input  logic [DATA_W-1:0]         in_datax,
    input  logic [DATA_W-1:0]         in_datay,
    input  logic [TAG_W-1:0]          in_tagw,
    input  logic [ADDR_W-1:0]         in_addrw,
    input  logic [CDB_N-1:0]          cdb_valid,
    input  logic [CDB_N*TAG_W-1:0]    cdb_tag,
    input  logic [CDB_N*DATA_W-1:0]   cdb_data,
    output logic [ISSUE_N-1:0]        iss_valid,
    input  logic [ISSUE_N-1:0]        iss_ready,
    output logic [ISSUE_N*OP_W-1:0]   iss_op,
    output logic [ISSUE_N*DATA_W-1:0] iss_datax,
    output logic [ISSUE_N*DATA_W-1:0] iss_datay,
    output logic [ISSUE_N*TAG_W-1:0]  iss_tagw,
    output logic [ISSUE_N*ADDR_W-1:0] iss_addrw,
    output logic [$clog2(ENTRIES):0]  occupancy
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENTRIES);

    // Slot state. older_reg[i][j] = 1 means slot j is older than slot i.
    logic [ENTRIES-1:0] valid_reg;
    logic [ENTRIES-1:0] older_reg [ENTRIES];
    logic [OP_W-1:0]    op_reg    [ENTRIES];
    logic [TAG_W-1:0]   tagx_reg  [ENTRIES];
    logic [TAG_W-1:0]   tagy_reg  [ENTRIES];
    logic [DATA_W-1:0]  datax_reg [ENTRIES];
    logic [DATA_W-1:0]  datay_reg [ENTRIES];
    logic [TAG_W-1:0]   tagw_reg  [ENTRIES];
    logic [ADDR_W-1:0]  addrw_reg [ENTRIES];
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;

    logic [ENTRIES-1:0] ready;
    logic [DATA_W:0]    wake_x [ENTRIES];
    logic [DATA_W:0]    wake_y [ENTRIES];
    logic [DATA_W:0]    cap_x;
    logic [DATA_W:0]    cap_y;
    logic               accept;
    logic [IDX_W-1:0]   alloc_idx;
    logic [ENTRIES-1:0] alloc_oh;
    logic [ENTRIES-1:0] pick     [ISSUE_N];
    logic [IDX_W-1:0]   pick_idx [ISSUE_N];
    logic [ISSUE_N-1:0] fire;
    logic [ENTRIES-1:0] free_mask;
    logic [CNT_W-1:0]   fire_cnt;

    // Returns {hit, data}; the lowest-numbered matching bus wins, tag 0 never matches.
    function automatic logic [DATA_W:0] cdb_match(input logic [TAG_W-1:0] tag);
        logic [DATA_W:0] res;
        res = '0;
        for (int k = CDB_N - 1; k >= 0; k--) begin
            if (cdb_valid[k] && (tag != '0) && (cdb_tag[k*TAG_W +: TAG_W] == tag)) begin
                res = {1'b1, cdb_data[k*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_slot
            assign ready[gi]  = valid_reg[gi] && (tagx_reg[gi] == '0) && (tagy_reg[gi] == '0);
            assign wake_x[gi] = cdb_match(tagx_reg[gi]);
            assign wake_y[gi] = cdb_match(tagy_reg[gi]);
        end
    endgenerate

    assign cap_x     = cdb_match(in_tagx);
    assign cap_y     = cdb_match(in_tagy);
    assign in_ready  = rdy && (count_reg < FULL_CNT);
    assign accept    = in_valid && in_ready && !flush;
    assign occupancy = count_reg;

    always_comb begin
        alloc_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_reg[i]) alloc_idx = IDX_W'(i);
        end
        alloc_oh = '0;
        if (accept) alloc_oh[alloc_idx] = 1'b1;
    end

    // Each port takes the slot with no older candidate left after earlier ports picked.
    always_comb begin
        logic [ENTRIES-1:0] avail;
        avail = ready;
        for (int p = 0; p < ISSUE_N; p++) begin
            pick[p]     = '0;
            pick_idx[p] = '0;
            for (int i = 0; i < ENTRIES; i++) begin
                if (avail[i] && ((older_reg[i] & avail) == '0)) begin
                    pick[p][i]  = 1'b1;
                    pick_idx[p] = IDX_W'(i);
                end
            end
            avail = avail & ~pick[p];
        end
    end

    generate
        for (genvar gi = 0; gi < ISSUE_N; gi++) begin : g_port
            assign iss_valid[gi]                  = rdy && !flush && (pick[gi] != '0);
            assign fire[gi]                       = iss_valid[gi] && iss_ready[gi];
            assign iss_op[gi*OP_W +: OP_W]        = op_reg[pick_idx[gi]];
            assign iss_datax[gi*DATA_W +: DATA_W] = datax_reg[pick_idx[gi]];
            assign iss_datay[gi*DATA_W +: DATA_W] = datay_reg[pick_idx[gi]];
            assign iss_tagw[gi*TAG_W +: TAG_W]    = tagw_reg[pick_idx[gi]];
            assign iss_addrw[gi*ADDR_W +: ADDR_W] = addrw_reg[pick_idx[gi]];
        end
    endgenerate

    always_comb begin
        free_mask = '0;
        fire_cnt  = '0;
        for (int p = 0; p < ISSUE_N; p++) begin
            if (fire[p]) begin
                free_mask = free_mask | pick[p];
                fire_cnt  = fire_cnt + CNT_W'(1);
            end
        end
        count_next = count_reg + CNT_W'(accept) - fire_cnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= '0;
            count_reg <= '0;
            for (int i = 0; i < ENTRIES; i++) older_reg[i] <= '0;
        end else if (rdy) begin
            if (flush) begin
                valid_reg <= '0;
                count_reg <= '0;
                for (int i = 0; i < ENTRIES; i++) older_reg[i] <= '0;
            end else begin
                valid_reg <= (valid_reg & ~free_mask) | alloc_oh;
                count_reg <= count_next;
                // A new slot is younger than every surviving slot; freed columns clear.
                for (int i = 0; i < ENTRIES; i++) begin
                    older_reg[i] <= alloc_oh[i] ? (valid_reg & ~free_mask)
                                                : (older_reg[i] & ~free_mask);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && !flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (alloc_oh[i]) begin
                    op_reg[i]    <= in_op;
                    tagw_reg[i]  <= in_tagw;
                    addrw_reg[i] <= in_addrw;
                    tagx_reg[i]  <= cap_x[DATA_W] ? '0 : in_tagx;
                    datax_reg[i] <= cap_x[DATA_W] ? cap_x[DATA_W-1:0] : in_datax;
                    tagy_reg[i]  <= cap_y[DATA_W] ? '0 : in_tagy;
                    datay_reg[i] <= cap_y[DATA_W] ? cap_y[DATA_W-1:0] : in_datay;
                end else if (valid_reg[i]) begin
                    if (wake_x[i][DATA_W]) begin
                        tagx_reg[i]  <= '0;
                        datax_reg[i] <= wake_x[i][DATA_W-1:0];
                    end
                    if (wake_y[i][DATA_W]) begin
                        tagy_reg[i]  <= '0;
                        datay_reg[i] <= wake_y[i][DATA_W-1:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_alu_pool.sv
// Bench for rs_alu_pool: directed scenarios plus a randomized run checked against
// an age-numbered slot model.
module tb_rs_alu_pool;
    localparam int ENTRIES = 8, ISSUE_N = 2, CDB_N = 3, TAG_W = 4, DATA_W = 32, OP_W = 6, ADDR_W = 5;
    localparam int PAY_W = OP_W + 2*DATA_W + TAG_W + ADDR_W;

    logic clk = 0, rst = 0, rdy = 1, flush = 0, in_valid = 0, in_ready;
    logic [OP_W-1:0] in_op = '0;
    logic [TAG_W-1:0] in_tagx = '0, in_tagy = '0, in_tagw = '0;
    logic [DATA_W-1:0] in_datax = '0, in_datay = '0;
    logic [ADDR_W-1:0] in_addrw = '0;
    logic [CDB_N-1:0] cdb_valid = '0;
    logic [CDB_N*TAG_W-1:0] cdb_tag = '0;
    logic [CDB_N*DATA_W-1:0] cdb_data = '0;
    logic [ISSUE_N-1:0] iss_valid, iss_ready = '0;
    logic [ISSUE_N*OP_W-1:0] iss_op;
    logic [ISSUE_N*DATA_W-1:0] iss_datax, iss_datay;
    logic [ISSUE_N*TAG_W-1:0] iss_tagw;
    logic [ISSUE_N*ADDR_W-1:0] iss_addrw;
    logic [$clog2(ENTRIES):0] occupancy;

    int n_total = 0, n_bad = 0;

    rs_alu_pool #(.ENTRIES(ENTRIES), .ISSUE_N(ISSUE_N), .CDB_N(CDB_N), .TAG_W(TAG_W),
                  .DATA_W(DATA_W), .OP_W(OP_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_tagx(in_tagx), .in_tagy(in_tagy), .in_datax(in_datax), .in_datay(in_datay),
        .in_tagw(in_tagw), .in_addrw(in_addrw), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_datax(iss_datax), .iss_datay(iss_datay), .iss_tagw(iss_tagw), .iss_addrw(iss_addrw),
        .occupancy(occupancy));

    always #5 clk = ~clk;

    // Reference model: each live slot carries an age number; smaller = older.
    bit                m_v  [ENTRIES];
    logic [OP_W-1:0]   m_op [ENTRIES];
    logic [TAG_W-1:0]  m_tx [ENTRIES], m_ty [ENTRIES], m_tw [ENTRIES];
    logic [DATA_W-1:0] m_dx [ENTRIES], m_dy [ENTRIES];
    logic [ADDR_W-1:0] m_aw [ENTRIES];
    int                m_age[ENTRIES];
    int m_cnt = 0, m_next_age = 0;
    int e_idx[ISSUE_N];
    logic [ISSUE_N-1:0] e_iv;
    logic e_in_ready;

    function automatic int bus_for(input logic [TAG_W-1:0] t);
        for (int k = 0; k < CDB_N; k++)
            if (cdb_valid[k] && t != 0 && cdb_tag[k*TAG_W +: TAG_W] == t) return k;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_v[i] = 0;
        m_cnt = 0;
    endtask

    task automatic model_expect();
        e_in_ready = rdy && (m_cnt < ENTRIES);
        for (int p = 0; p < ISSUE_N; p++) begin
            int best;
            best = -1;
            for (int i = 0; i < ENTRIES; i++)
                if (m_v[i] && m_tx[i] == 0 && m_ty[i] == 0 && (p == 0 || i != e_idx[0]) &&
                    (best < 0 || m_age[i] < m_age[best])) best = i;
            e_idx[p] = best;
            e_iv[p]  = rdy && !flush && best >= 0;
        end
    endtask

    task automatic model_update();
        int s, k;
        if (!rdy) return;
        if (flush) begin model_reset(); return; end
        s = -1;
        for (int i = ENTRIES - 1; i >= 0; i--) if (!m_v[i]) s = i;
        for (int i = 0; i < ENTRIES; i++) if (m_v[i]) begin
            k = bus_for(m_tx[i]);
            if (k >= 0) begin m_tx[i] = 0; m_dx[i] = cdb_data[k*DATA_W +: DATA_W]; end
            k = bus_for(m_ty[i]);
            if (k >= 0) begin m_ty[i] = 0; m_dy[i] = cdb_data[k*DATA_W +: DATA_W]; end
        end
        for (int p = 0; p < ISSUE_N; p++)
            if (e_iv[p] && iss_ready[p]) begin m_v[e_idx[p]] = 0; m_cnt--; end
        if (in_valid && e_in_ready) begin
            k = bus_for(in_tagx);
            m_tx[s] = (k >= 0) ? '0 : in_tagx;
            m_dx[s] = (k >= 0) ? cdb_data[k*DATA_W +: DATA_W] : in_datax;
            k = bus_for(in_tagy);
            m_ty[s] = (k >= 0) ? '0 : in_tagy;
            m_dy[s] = (k >= 0) ? cdb_data[k*DATA_W +: DATA_W] : in_datay;
            m_op[s] = in_op; m_tw[s] = in_tagw; m_aw[s] = in_addrw;
            m_age[s] = m_next_age++; m_v[s] = 1; m_cnt++;
        end
    endtask

    task automatic clock_step();
        model_expect();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        rdy = 1; flush = 0; in_valid = 0; cdb_valid = '0; iss_ready = '0;
    endtask

    task automatic set_disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] tx, input logic [DATA_W-1:0] dx,
                            input logic [TAG_W-1:0] ty, input logic [DATA_W-1:0] dy,
                            input logic [TAG_W-1:0] tw, input logic [ADDR_W-1:0] aw);
        in_valid = 1; in_op = op; in_tagx = tx; in_datax = dx; in_tagy = ty; in_datay = dy;
        in_tagw = tw; in_addrw = aw;
    endtask

    task automatic set_cdb(input int k, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        cdb_valid[k] = 1'b1; cdb_tag[k*TAG_W +: TAG_W] = t; cdb_data[k*DATA_W +: DATA_W] = d;
    endtask

    task automatic test_reset();
        rst = 0; rdy = 1; set_disp(6'h3f, 0, 1, 0, 2, 1, 1);
        repeat (2) @(posedge clk);
        #3;
        n_total++; if (iss_valid !== 2'b00) begin n_bad++; $display("FAIL reset_iss_valid got=%b exp=00", iss_valid); end
        n_total++; if (occupancy !== 0) begin n_bad++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        in_valid = 0; rst = 1; model_reset();
        #2;
        n_total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        clock_step();
        $display("test_reset done");
    endtask

    task automatic test_ready_dispatch();
        drive_idle(); set_disp(6'h01, 0, 5, 0, 7, 4'h1, 5'd3);
        #2;
        n_total++; if (iss_valid !== 2'b00) begin n_bad++; $display("FAIL disp_no_bypass got=%b exp=00", iss_valid); end
        clock_step(); in_valid = 0; #2;
        n_total++; if (iss_valid !== 2'b01) begin n_bad++; $display("FAIL disp_valid got=%b exp=01", iss_valid); end
        n_total++; if (iss_datax[31:0] !== 32'd5 || iss_datay[31:0] !== 32'd7)
            begin n_bad++; $display("FAIL disp_data got=%0d/%0d exp=5/7", iss_datax[31:0], iss_datay[31:0]); end
        n_total++; if (occupancy !== 1) begin n_bad++; $display("FAIL disp_occ got=%0d exp=1", occupancy); end
        set_cdb(0, 0, 32'h1111);
        clock_step(); cdb_valid = '0; #2;
        n_total++; if (iss_valid !== 2'b01 || iss_datax[31:0] !== 32'd5)
            begin n_bad++; $display("FAIL tag0_nowake got=%b/%h exp=01/5", iss_valid, iss_datax[31:0]); end
        iss_ready = 2'b01;
        clock_step(); iss_ready = '0; #2;
        n_total++; if (occupancy !== 0 || iss_valid !== 2'b00)
            begin n_bad++; $display("FAIL disp_free got=%0d/%b exp=0/00", occupancy, iss_valid); end
        $display("test_ready_dispatch done");
    endtask

    task automatic test_wakeup();
        drive_idle(); set_disp(6'h02, 3, 0, 5, 0, 4'h2, 5'd4);
        clock_step(); in_valid = 0; #2;
        n_total++; if (iss_valid !== 2'b00) begin n_bad++; $display("FAIL wake_wait got=%b exp=00", iss_valid); end
        set_cdb(1, 5, 32'h2222); set_cdb(2, 5, 32'h3333);
        clock_step(); cdb_valid = '0;
        set_cdb(2, 3, 32'hABCD); #2;
        n_total++; if (iss_valid !== 2'b00) begin n_bad++; $display("FAIL wake_no_bypass got=%b exp=00", iss_valid); end
        clock_step(); cdb_valid = '0; #2;
        n_total++; if (iss_valid !== 2'b01) begin n_bad++; $display("FAIL wake_valid got=%b exp=01", iss_valid); end
        n_total++; if (iss_datax[31:0] !== 32'hABCD) begin n_bad++; $display("FAIL wake_datax got=%h exp=abcd", iss_datax[31:0]); end
        n_total++; if (iss_datay[31:0] !== 32'h2222) begin n_bad++; $display("FAIL wake_lowbus got=%h exp=2222", iss_datay[31:0]); end
        iss_ready = 2'b01;
        clock_step(); iss_ready = '0;
        $display("test_wakeup done");
    endtask

    task automatic test_capture();
        drive_idle(); set_disp(6'h03, 0, 11, 4, 32'hDEAD, 4'h3, 5'd5); set_cdb(0, 4, 9);
        clock_step(); drive_idle(); #2;
        n_total++; if (iss_valid !== 2'b01 || iss_datay[31:0] !== 32'd9 || iss_datax[31:0] !== 32'd11)
            begin n_bad++; $display("FAIL capture got=%b/%0d/%0d exp=01/11/9", iss_valid, iss_datax[31:0], iss_datay[31:0]); end
        iss_ready = 2'b01;
        clock_step(); iss_ready = '0;
        $display("test_capture done");
    endtask

    task automatic test_order_full();
        drive_idle();
        for (int i = 0; i < ENTRIES; i++) begin
            set_disp(OP_W'(i), (i == 2) ? 4'd7 : (i == 5) ? 4'd8 : 4'd9, 0, 0, DATA_W'(100 + i), TAG_W'(i), ADDR_W'(i));
            #2;
            n_total++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, in_ready); end
            clock_step();
        end
        #2;
        n_total++; if (in_ready !== 1'b0 || occupancy !== 8)
            begin n_bad++; $display("FAIL full got=%b/%0d exp=0/8", in_ready, occupancy); end
        clock_step(); in_valid = 0; #2;
        n_total++; if (occupancy !== 8) begin n_bad++; $display("FAIL full_hold got=%0d exp=8", occupancy); end
        set_cdb(0, 7, 32'h70); set_cdb(1, 8, 32'h80);
        clock_step(); cdb_valid = '0; #2;
        n_total++; if (iss_valid !== 2'b11 || iss_addrw[4:0] !== 5'd2 || iss_addrw[9:5] !== 5'd5)
            begin n_bad++; $display("FAIL order got=%b/%0d/%0d exp=11/2/5", iss_valid, iss_addrw[4:0], iss_addrw[9:5]); end
        iss_ready = 2'b01;
        clock_step(); iss_ready = '0; #2;
        n_total++; if (occupancy !== 7 || in_ready !== 1'b1)
            begin n_bad++; $display("FAIL after_hs got=%0d/%b exp=7/1", occupancy, in_ready); end
        n_total++; if (iss_valid !== 2'b01 || iss_addrw[4:0] !== 5'd5 || iss_datax[31:0] !== 32'h80)
            begin n_bad++; $display("FAIL next_pick got=%b/%0d exp=01/5", iss_valid, iss_addrw[4:0]); end
        $display("test_order_full done");
    endtask

    task automatic test_stall_flush();
        iss_ready = 2'b01;
        clock_step(); iss_ready = '0; #2;
        n_total++; if (occupancy !== 6) begin n_bad++; $display("FAIL pre_stall_occ got=%0d exp=6", occupancy); end
        rdy = 0; set_cdb(0, 9, 32'h99); set_disp(6'h0a, 0, 1, 0, 1, 1, 1); iss_ready = 2'b11;
        for (int c = 0; c < 3; c++) begin
            #2;
            n_total++; if (iss_valid !== 2'b00 || in_ready !== 1'b0 || occupancy !== 6)
                begin n_bad++; $display("FAIL stall[%0d] got=%b/%b/%0d exp=00/0/6", c, iss_valid, in_ready, occupancy); end
            clock_step();
        end
        drive_idle(); #2;
        n_total++; if (iss_valid !== 2'b00 || occupancy !== 6)
            begin n_bad++; $display("FAIL stall_lost_cdb got=%b/%0d exp=00/6", iss_valid, occupancy); end
        set_cdb(0, 9, 32'h99);
        clock_step(); cdb_valid = '0; #2;
        n_total++; if (iss_valid !== 2'b11 || iss_addrw[4:0] !== 5'd0 || iss_addrw[9:5] !== 5'd1)
            begin n_bad++; $display("FAIL wake_all got=%b/%0d/%0d exp=11/0/1", iss_valid, iss_addrw[4:0], iss_addrw[9:5]); end
        flush = 1; set_disp(6'h0b, 0, 1, 0, 1, 1, 1); iss_ready = 2'b11; #2;
        n_total++; if (iss_valid !== 2'b00) begin n_bad++; $display("FAIL flush_iss got=%b exp=00", iss_valid); end
        clock_step(); drive_idle(); #2;
        n_total++; if (occupancy !== 0 || iss_valid !== 2'b00)
            begin n_bad++; $display("FAIL flush_clear got=%0d/%b exp=0/00", occupancy, iss_valid); end
        $display("test_stall_flush done");
    endtask

    task automatic test_async_reset();
        drive_idle();
        for (int i = 0; i < 2; i++) begin set_disp(6'h0c, 0, 1, 0, 2, 1, 1); clock_step(); end
        drive_idle(); #2;
        n_total++; if (occupancy !== 2) begin n_bad++; $display("FAIL ares_pre got=%0d exp=2", occupancy); end
        rst = 0; #1;
        n_total++; if (occupancy !== 0 || iss_valid !== 2'b00)
            begin n_bad++; $display("FAIL ares_now got=%0d/%b exp=0/00", occupancy, iss_valid); end
        model_reset(); #1; rst = 1;
        clock_step();
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        logic [PAY_W-1:0] got, exp;
        for (int c = 0; c < 600; c++) begin
            rdy = ($urandom_range(0, 9) != 0); flush = ($urandom_range(0, 49) == 0);
            in_valid = ($urandom_range(0, 9) < 6); in_op = OP_W'($urandom);
            in_tagx = $urandom_range(0, 1) ? '0 : TAG_W'($urandom_range(1, 7));
            in_tagy = $urandom_range(0, 1) ? '0 : TAG_W'($urandom_range(1, 7));
            in_datax = $urandom; in_datay = $urandom; in_tagw = TAG_W'($urandom); in_addrw = ADDR_W'($urandom);
            for (int k = 0; k < CDB_N; k++) begin
                cdb_valid[k] = ($urandom_range(0, 2) == 0);
                cdb_tag[k*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 7));
                cdb_data[k*DATA_W +: DATA_W] = $urandom;
            end
            iss_ready = ISSUE_N'($urandom);
            #2;
            model_expect();
            n_total++; if (iss_valid !== e_iv) begin n_bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, iss_valid, e_iv); end
            n_total++; if (in_ready !== e_in_ready) begin n_bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", c, in_ready, e_in_ready); end
            n_total++; if (occupancy !== m_cnt[$clog2(ENTRIES):0]) begin n_bad++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", c, occupancy, m_cnt); end
            for (int p = 0; p < ISSUE_N; p++) if (e_iv[p]) begin
                got = {iss_op[p*OP_W +: OP_W], iss_datax[p*DATA_W +: DATA_W], iss_datay[p*DATA_W +: DATA_W],
                       iss_tagw[p*TAG_W +: TAG_W], iss_addrw[p*ADDR_W +: ADDR_W]};
                exp = {m_op[e_idx[p]], m_dx[e_idx[p]], m_dy[e_idx[p]], m_tw[e_idx[p]], m_aw[e_idx[p]]};
                n_total++; if (got !== exp) begin n_bad++; $display("FAIL rnd_payload cyc=%0d port=%0d got=%h exp=%h", c, p, got, exp); end
            end
            $display("rnd cyc=%0d rdy=%b flush=%b disp=%b iss=%b hs=%b occ=%0d", c, rdy, flush,
                     in_valid && in_ready && !flush, iss_valid, iss_valid & iss_ready, occupancy);
            clock_step();
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_ready_dispatch();
        test_wakeup();
        test_capture();
        test_order_full();
        test_stall_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
